// File: rtl/nrzi_decode_if.sv
// NRZI receive link: line level, bit strobe and EOP in, decoded bit out.
// master drives d_plus/shift_enable/eop, slave (decoder) drives d_orig.
interface nrzi_decode_if;
  logic d_plus;
  logic shift_enable;
  logic eop;
  logic d_orig;

  modport master (
    output d_plus,
    output shift_enable,
    output eop,
    input  d_orig
  );

  modport slave (
    input  d_plus,
    input  shift_enable,
    input  eop,
    output d_orig
  );
endinterface

// File: rtl/nrzi_decode.sv
// USB receive NRZI decoder: d_orig = 1 when line held, 0 when it toggled.
// Ports: clk, n_rst (sync, active-high), bus (slave: d_plus/shift_enable/eop in, d_orig out).
module nrzi_decode #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic         clk,
  input logic         n_rst,
  nrzi_decode_if.slave bus
);

  logic cur_q;
  logic last_q;
  logic last_d;

  // EOP forces the next packet to decode its first bit against idle.
  always_comb begin
    last_d = last_q;
    unique case (1'b1)
      (bus.shift_enable && bus.eop):  last_d = IDLE_LEVEL;
      (bus.shift_enable && !bus.eop): last_d = cur_q;
      (!bus.shift_enable):            last_d = last_q;
      default:                        last_d = last_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      cur_q  <= IDLE_LEVEL;
      last_q <= IDLE_LEVEL;
    end else begin
      cur_q  <= bus.d_plus;
      last_q <= last_d;
    end
  end

  assign bus.d_orig = ~(cur_q ^ last_q);

  a_no_x : assert property (
    @(posedge clk) disable iff (n_rst)
    !$isunknown(bus.d_orig)
  );

  a_eop_idle : assert property (
    @(posedge clk) disable iff (n_rst)
    (bus.shift_enable && bus.eop && bus.d_plus == IDLE_LEVEL)
      |=> bus.d_orig
  );

endmodule

// File: tb/tb_nrzi_decode.sv
// Directed bench for nrzi_decode: reset, toggle, re-base, EOP, mid reset.
// Expected values hand-derived from the NRZI rule d_orig = ~(cur ^ last).
module tb_nrzi_decode;

  logic tb_clk;
  logic n_rst;
  int   checks;
  int   errors;

  nrzi_decode_if bus ();

  nrzi_decode #(.IDLE_LEVEL(1'b1)) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst = 1'b1;
    bus.d_plus = 1'b1;
    bus.shift_enable = 1'b0;
    bus.eop = 1'b0;

    step();
    chk("rst_e1", bus.d_orig, 1'b1);
    step();
    chk("rst_e2", bus.d_orig, 1'b1);
    chk("rst_cur", dut.cur_q, 1'b1);
    chk("rst_last", dut.last_q, 1'b1);

    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_hold", bus.d_orig, 1'b1);
    end
    chk("idle_cur", dut.cur_q, 1'b1);
    chk("idle_last", dut.last_q, 1'b1);

    bus.d_plus = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("toggle0", bus.d_orig, 1'b0);
    end

    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("rebase1", bus.d_orig, 1'b1);
    step();
    chk("rebase1_hold", bus.d_orig, 1'b1);
    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("rebase2", bus.d_orig, 1'b1);

    bus.d_plus = 1'b1;
    step();
    chk("toggle1", bus.d_orig, 1'b0);
    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("rebase3", bus.d_orig, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold8", bus.d_orig, 1'b1);
    end
    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("rebase4", bus.d_orig, 1'b1);
    bus.d_plus = 1'b0;
    step();
    chk("toggle2", bus.d_orig, 1'b0);

    // cur=0,last=1: strobe so last=0, then line to 1
    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("pre_eop_rebase", bus.d_orig, 1'b1);
    bus.d_plus = 1'b1;
    step();
    chk("pre_eop_last", dut.last_q, 1'b0);
    chk("pre_eop_dorig", bus.d_orig, 1'b0);

    bus.shift_enable = 1'b1;
    bus.eop = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    bus.eop = 1'b0;
    chk("eop_last", dut.last_q, 1'b1);
    chk("eop_dorig", bus.d_orig, 1'b1);

    // line to 0, then eop alone must leave last_q alone
    bus.d_plus = 1'b0;
    step();
    chk("post_eop_tog", bus.d_orig, 1'b0);
    bus.eop = 1'b1;
    step();
    bus.eop = 1'b0;
    chk("eop_only_last", dut.last_q, 1'b1);
    chk("eop_only_dorig", bus.d_orig, 1'b0);

    // simultaneous toggle and strobe: last takes old cur (0), cur takes 1
    bus.d_plus = 1'b1;
    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("simul_last", dut.last_q, 1'b0);
    chk("simul_dorig", bus.d_orig, 1'b0);

    bus.d_plus = 1'b0;
    bus.shift_enable = 1'b1;
    step();
    bus.shift_enable = 1'b0;
    chk("pre_rst_dorig", bus.d_orig, 1'b0);

    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    chk("mid_rst_cur", dut.cur_q, 1'b1);
    chk("mid_rst_last", dut.last_q, 1'b1);
    chk("mid_rst_dorig", bus.d_orig, 1'b1);
    step();
    chk("post_rst_dorig", bus.d_orig, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrzi_decode.md
Name: nrzi_decode

Overview:
USB receive-path NRZI decoder. It samples the already-synchronized D+ line level every clock and compares it with the level held at the previous bit boundary. It outputs the decoded bit: 1 when the line did not change, 0 when it toggled. It sits between the edge/sync logic and the receive shift register. The bit-timing block supplies shift_enable, and the EOP detector supplies eop.

Parameters:
IDLE_LEVEL, 1'b1, line level (J/idle) that reset and end-of-packet force into both level registers.

Ports:
clk  input  1  system clock; all state updates on rising edge.
n_rst  input  1  reset; synchronous, active-high (1 = reset, sampled on rising clk edge). The port keeps the codebase name n_rst, but polarity is active-high.
d_plus  input  1  synchronized D+ line level.
shift_enable  input  1  one-clock strobe marking the bit-sample point of the current bit period.
eop  input  1  end-of-packet indication from the EOP detector; qualified by shift_enable.
d_orig  output  1  decoded NRZI bit.

Behaviour:
- State: two 1-bit registers.
  - cur_q: current line level.
  - last_q: line level captured at the previous bit boundary.
- Reset (n_rst=1 at rising edge): cur_q <= IDLE_LEVEL and last_q <= IDLE_LEVEL. Reset has priority over all other inputs, including mid-packet. d_orig reads 1 during and immediately after reset.
- cur_q updates every cycle with cur_q <= d_plus, regardless of shift_enable.
- last_q updates on shift_enable:
  - shift_enable=1, eop=0: last_q <= cur_q (old value of cur_q, i.e. the level before this edge).
  - shift_enable=1, eop=1: last_q <= IDLE_LEVEL, so the next packet's first bit decodes against idle.
  - shift_enable=0: last_q holds. eop alone has no effect.
- d_orig is combinational from registers only: d_orig = ~(cur_q ^ last_q), i.e. 1 when levels match, 0 when different. No combinational path from d_plus.
- Latency: a d_plus change appears on d_orig one rising edge later. A shift_enable strobe re-bases last_q, so d_orig returns to 1 one edge after the strobe if the line is stable.
- shift_enable held high for multiple cycles: last_q tracks cur_q each cycle, so d_orig settles to 1 unless the line toggles every cycle. Legal, no error flag.
- Simultaneous d_plus change and shift_enable: last_q takes the pre-edge cur_q and cur_q takes the new d_plus. d_orig = 0 after the edge, correctly reporting the toggle for the next bit.
- No X propagation: every register has a defined reset and every update path assigns a known value.
- Implementation: a two-register always block plus the XNOR, with the IDLE_LEVEL parameter and defensive handling described above. Optionally add assertions: d_orig is never X after reset, and d_orig == 1 after any shift_enable&eop strobe while the line is idle.

Test Plan:
- Reset: n_rst=1 for 2 edges with d_plus=1, then release and hold d_plus=1 for 3 cycles -> d_orig=1 throughout, cur_q=last_q=1.
- Toggle detect: from idle, d_plus 1->0 and no shift_enable for 4 cycles -> d_orig=0 from the first edge after the change, held at 0.
- Re-base: continuing, pulse shift_enable for one cycle -> d_orig returns to 1 one edge after the strobe. A second strobe with d_plus still 0 keeps d_orig=1.
- Toggle back: d_plus 0->1 -> d_orig=0 next edge. Strobe shift_enable -> d_orig=1. Hold 8 cycles, strobe again -> still 1. Drive d_plus=0 -> d_orig=0.
- EOP: with last_q=0 and d_plus=1, strobe shift_enable with eop=1 -> last_q=1 and d_orig=1. Assert eop without shift_enable -> no change in last_q.
- Mid-operation reset: with d_plus=0 and d_orig=0, assert n_rst for 1 edge -> cur_q=last_q=1 and d_orig=1. After release, d_orig=0 one edge later since d_plus is still 0.
